// File: rtl/sccb_config_sequencer.sv
// sccb_config_sequencer: walks a ROM register table and issues SCCB 3-phase writes to the camera
module sccb_config_sequencer #(
    parameter int CLK_DIV = 125,
    parameter logic [7:0] DEV_ADDR = 8'h42,
    parameter int DELAY_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        resend,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sioc,
    output logic        siod_o,
    output logic        siod_oe,
    output logic        busy,
    output logic        config_finished
);
    localparam logic [3:0] FETCH = 4'd0, WAIT_ROM = 4'd1, DECODE = 4'd2, START = 4'd3, BITS = 4'd4,
                           STOP = 4'd5, GAP = 4'd6, DELAY = 4'd7, DONE = 4'd8;

    logic [3:0]  state;
    logic [31:0] cnt;
    logic [1:0]  q;
    logic [4:0]  bit_idx;
    logic [26:0] sh;
    logic [15:0] rom_q;
    logic        resend_q, pend;
    logic        rise, wrap, qend, dly_end, last;
    logic        n_sioc, n_siod, n_oe;

    assign rise = resend & ~resend_q;
    assign wrap = cnt == 32'(CLK_DIV - 1);
    assign qend = wrap && q == 2'd3;
    assign dly_end = cnt == 32'(DELAY_CYCLES - 1);
    assign last = rom_addr == 8'hFF;
    assign busy = state inside {START, BITS, STOP, GAP, DELAY};
    assign config_finished = state == DONE;

    // bus level for the current state and quarter; ACK slots release the line
    always_comb begin
        n_sioc = (state == BITS) ? q[1] : (state == STOP) ? (q != 2'd0) : 1'b1;
        n_siod = (state == START) ? ~q[1] : (state == BITS) ? sh[26] : (state == STOP) ? q[1] : 1'b1;
        n_oe   = (state == BITS) ? !(bit_idx inside {5'd8, 5'd17, 5'd26}) : 1'b1;
    end

    // registered bus outputs; reset forces idle immediately without a stop condition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sioc    <= 1'b1;
            siod_o  <= 1'b1;
            siod_oe <= 1'b1;
        end else begin
            sioc    <= n_sioc;
            siod_o  <= n_siod;
            siod_oe <= n_oe;
        end
    end

    // table walker, quarter timer and resend bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            rom_addr <= 8'd0;
            cnt      <= 32'd0;
            q        <= 2'd0;
            bit_idx  <= 5'd0;
            sh       <= 27'd0;
            rom_q    <= 16'd0;
            resend_q <= 1'b1;
            pend     <= 1'b0;
        end else begin
            resend_q <= resend;
            if (rise && state != DONE) pend <= 1'b1;
            case (state)
                FETCH: state <= WAIT_ROM;
                WAIT_ROM: begin
                    rom_q <= rom_data;
                    state <= DECODE;
                end
                DECODE: begin
                    cnt     <= 32'd0;
                    q       <= 2'd0;
                    bit_idx <= 5'd0;
                    sh      <= {DEV_ADDR, 1'b1, rom_q[15:8], 1'b1, rom_q[7:0], 1'b1};
                    state   <= (rom_q == 16'hFFFF) ? DONE : (rom_q == 16'hF0F0) ? DELAY : START;
                end
                START, BITS, STOP, GAP: begin
                    cnt <= wrap ? 32'd0 : cnt + 32'd1;
                    if (wrap) q <= q + 2'd1;
                    if (qend) begin
                        case (state)
                            START: state <= BITS;
                            BITS: begin
                                if (bit_idx == 5'd26) state <= STOP;
                                bit_idx <= bit_idx + 5'd1;
                                sh      <= sh << 1;
                            end
                            STOP: state <= GAP;
                            default: begin
                                state <= last ? DONE : FETCH;
                                if (!last) rom_addr <= rom_addr + 8'd1;
                            end
                        endcase
                    end
                end
                DELAY: begin
                    cnt <= cnt + 32'd1;
                    if (dly_end) begin
                        state <= last ? DONE : FETCH;
                        if (!last) rom_addr <= rom_addr + 8'd1;
                    end
                end
                DONE: begin
                    if (pend || rise) begin
                        pend     <= 1'b0;
                        rom_addr <= 8'd0;
                        state    <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: doc/sccb_config_sequencer.md
# sccb_config_sequencer

Walks a register table held in an external synchronous ROM and issues each entry to the OV7670 as an SCCB 3-phase write: device address, register, value. Sits between the camera-control logic and the camera's SIOC/SIOD pins, clocked from the 50 MHz system clock. Supports delay entries, an end-of-table marker, button-driven resend, and a `config_finished` flag for status LEDs.

## Interface
- `CLK_DIV`, 125 — `clk` cycles per SCCB quarter-bit. SCCB bit period = 4*CLK_DIV; 125 gives 100 kHz at 50 MHz.
- `DEV_ADDR`, 8'h42 — SCCB write address of the camera.
- `DELAY_CYCLES`, 500000 — `clk` cycles waited on a delay entry.
- `clk` — input, 1 bit, system clock.
- `reset` — input, 1 bit. Asynchronous, active-high.
- `resend` — input, 1 bit, debounced level; a rising edge requests reconfiguration.
- `rom_addr` — output, 8 bits, table index.
- `rom_data` — input, 16 bits, entry {reg[15:8], val[7:0]}, valid 1 cycle after `rom_addr` changes.
- `sioc` — output, 1 bit, SCCB clock.
- `siod_o` — output, 1 bit, SCCB data value.
- `siod_oe` — output, 1 bit. 1 = drive `siod_o`; 0 = release to the pull-up. Tristate is at top level.
- `busy` — output, 1 bit, high while a write or delay is in progress.
- `config_finished` — output, 1 bit, high after the end marker, until restart.

## Operation
- **States:** FETCH, WAIT_ROM, DECODE, START, BITS, STOP, GAP, DELAY, DONE.
- **Reset values:** state FETCH; `rom_addr`=0; `sioc`=1; `siod_o`=1; `siod_oe`=1; `busy`=0; `config_finished`=0; resend-pending flag cleared.
- **FETCH:** present `rom_addr`, then go to WAIT_ROM for 1 cycle. DECODE uses the registered `rom_data`.
- **DECODE:**
  - 16'hFFFF → DONE.
  - 16'hF0F0 → DELAY.
  - Otherwise load a 27-bit shift register with {DEV_ADDR, z, reg, z, val, z}, where z marks a released (don't-care ACK) bit, then go to START.
- **Quarter timer:** counts 0..CLK_DIV-1. Every state from START through GAP advances one quarter per wrap.
- **START (4 quarters):**
  - q0–q1: `sioc`=1, `siod_o`=1.
  - q2–q3: `sioc`=1, `siod_o`=0.
- **BITS (27 bits × 4 quarters):**
  - q0: `sioc`=0, update data.
  - q1: `sioc`=0.
  - q2–q3: `sioc`=1.
  - Data is MSB first.
  - During the z positions (bit indices 8, 17, 26), `siod_oe`=0; otherwise `siod_oe`=1. The ACK is not sampled.
- **STOP (4 quarters):**
  - q0: `sioc`=0, `siod_o`=0.
  - q1: `sioc`=1, `siod_o`=0.
  - q2–q3: `sioc`=1, `siod_o`=1.
- **GAP (4 quarters):** bus idle. Then increment `rom_addr` and go to FETCH.
- **DELAY:** count DELAY_CYCLES with bus idle, increment `rom_addr`, go to FETCH.
- **busy:** 1 in START, BITS, STOP, GAP, DELAY; 0 elsewhere.
- **Table overrun:** if `rom_addr` would increment past 255, go to DONE. No wrap.
- **DONE:** `config_finished`=1, bus idle. If the resend-pending flag is set, or a `resend` rising edge arrives: clear `config_finished` and the flag, set `rom_addr`=0, go to FETCH.
- **Resend outside DONE:** a rising edge sets resend-pending. The current table pass completes unaltered, then restarts from DONE. Multiple edges collapse into one restart.
- **Edge detection:** `resend` is registered once for edge detection. A level held high through reset does not trigger a restart.
- **Reset mid-transaction:** the bus returns immediately (asynchronously) to idle 1/1. No stop condition is emitted; the next start is legal SCCB.

## Timing
- One table write occupies 4+108+4+4 = 120 quarters, i.e. 120*CLK_DIV cycles, plus 3 fetch/decode cycles.
- `rom_addr` changes only on the FETCH entry cycle; the ROM has 1 cycle of latency.
- `sioc` and `siod_*` are registered outputs. They change one cycle after the quarter-timer wrap.
- `siod` transitions occur only while `sioc`=0, except the start and stop edges, which occur while `sioc`=1.
- `config_finished` rises 1 cycle after DECODE sees FFFF.
- After reset release, the first `sioc` fall (the end of START) occurs 4 + 4*CLK_DIV cycles later.

## Test plan
- **Single write:** CLK_DIV=2, ROM {0: 16'h1280, 1: FFFF}. Decode the SIOD bitstream on SIOC rising edges → bytes 0x42, 0x12, 0x80 with released ACK slots; start and stop conditions are correct; `config_finished`=1 after 240+3 cycles; `rom_addr` ends at 1.
- **Delay entry:** ROM {0: F0F0, 1: 1100, 2: FFFF}, DELAY_CYCLES=50. → No bus activity for 50 cycles; `busy`=1 throughout; then one write of 0x42/0x11/0x00; `config_finished`=1.
- **Resend in DONE:** pulse `resend` after `config_finished`. → `config_finished` drops next cycle; `rom_addr`=0; the full table is replayed identically.
- **Resend mid-write:** pulse `resend` during BITS of entry 0, then a second pulse. → The current pass completes unaltered; exactly one restart follows.
- **Overrun:** ROM with no FFFF (all 16'h0101). → 256 writes, then DONE with `rom_addr`=255; no wrap to 0.
- **Async reset mid-BITS:** assert `reset` for 3 cycles. → `sioc`, `siod_o`, `siod_oe` are 1 immediately, without waiting for a clock edge; `config_finished`=0; the sequence restarts at entry 0 with a clean start condition.
